// File: rtl/io_handshake_ctrl.sv
// IN/OUT instruction sequencer: stalls IN until a debounced confirm press,
// then pulses flagIN with the captured switch word; OUT latches the display.
module io_handshake_ctrl #(
  parameter int DATA_W   = 32,
  parameter int DEBOUNCE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_req,
  input  logic              out_req,
  input  logic              btn,
  input  logic [DATA_W-1:0] switches,
  input  logic [DATA_W-1:0] out_data,
  output logic              flagIN,
  output logic [DATA_W-1:0] in_data,
  output logic              in_waiting,
  output logic [DATA_W-1:0] out_display,
  output logic              out_strobe
);

  localparam int               CNT_W   = $clog2(DEBOUNCE) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    ACK
  } state_t;

  logic              btn_m;
  logic              btn_s;
  logic [DATA_W-1:0] sw_m;
  logic [DATA_W-1:0] sw_s;
  logic              btn_db;
  logic              press;
  logic [CNT_W-1:0]  cnt;
  state_t            state;

  // Two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      sw_m  <= switches;
      sw_s  <= sw_m;
    end
  end

  // A level change is accepted only after DEBOUNCE consecutive differing samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_db <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == btn_db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        btn_db <= btn_s;
        cnt    <= '0;
        press  <= btn_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Abort (in_req low) takes priority over a press arriving in the same cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      flagIN     <= 1'b0;
      in_waiting <= 1'b0;
      in_data    <= '0;
    end else begin
      flagIN <= 1'b0;
      case (state)
        IDLE: begin
          if (in_req) begin
            state      <= WAIT_PRESS;
            in_waiting <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          if (!in_req) begin
            state      <= IDLE;
            in_waiting <= 1'b0;
          end else if (press) begin
            state      <= ACK;
            in_waiting <= 1'b0;
            in_data    <= sw_s;
            flagIN     <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          in_waiting <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_display <= '0;
      out_strobe  <= 1'b0;
    end else begin
      out_strobe <= out_req;
      if (out_req) begin
        out_display <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Self-checking bench for io_handshake_ctrl: directed vector table, hand-written
// corner sequences, and randomized traffic against a window-based reference model.
module tb_io_handshake_ctrl;

  localparam int DEB = 4;

  logic        clock;
  logic        reset;
  logic        in_req;
  logic        out_req;
  logic        btn;
  logic [31:0] switches;
  logic [31:0] out_data;
  logic        flagIN;
  logic [31:0] in_data;
  logic        in_waiting;
  logic [31:0] out_display;
  logic        out_strobe;

  int tests;
  int failures;

  io_handshake_ctrl #(.DATA_W(32), .DEBOUNCE(DEB)) dut (
    .clock(clock),
    .reset(reset),
    .in_req(in_req),
    .out_req(out_req),
    .btn(btn),
    .switches(switches),
    .out_data(out_data),
    .flagIN(flagIN),
    .in_data(in_data),
    .in_waiting(in_waiting),
    .out_display(out_display),
    .out_strobe(out_strobe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: IN transaction phase flags, debounced level decided by a
  // sliding window of the last DEB synchronized samples, and the OUT latch.
  logic        mWaiting;
  logic        mAck;
  logic        mPress;
  logic        mLevel;
  logic        win[$];
  logic        bPipe[2];
  logic [31:0] swPipe[2];
  logic [31:0] mInData;
  logic [31:0] mDisp;
  logic        mStrobe;

  task automatic modelReset();
    mWaiting = 1'b0;
    mAck     = 1'b0;
    mPress   = 1'b0;
    mLevel   = 1'b0;
    win.delete();
    for (int i = 0; i < DEB; i++) win.push_back(1'b0);
    bPipe[0]  = 1'b0;
    bPipe[1]  = 1'b0;
    swPipe[0] = '0;
    swPipe[1] = '0;
    mInData   = '0;
    mDisp     = '0;
    mStrobe   = 1'b0;
  endtask

  task automatic modelStep();
    logic        bs;
    logic [31:0] ss;
    logic        pressOld;
    logic        allOpp;
    bs       = bPipe[1];
    ss       = swPipe[1];
    pressOld = mPress;
    if (mAck) begin
      mAck = 1'b0;
    end else if (mWaiting) begin
      if (!in_req) begin
        mWaiting = 1'b0;
      end else if (pressOld) begin
        mInData  = ss;
        mWaiting = 1'b0;
        mAck     = 1'b1;
      end
    end else if (in_req) begin
      mWaiting = 1'b1;
    end
    win.push_back(bs);
    void'(win.pop_front());
    allOpp = 1'b1;
    foreach (win[i]) if (win[i] == mLevel) allOpp = 1'b0;
    if (allOpp) begin
      mLevel = bs;
      mPress = bs;
    end else begin
      mPress = 1'b0;
    end
    if (out_req) begin
      mDisp   = out_data;
      mStrobe = 1'b1;
    end else begin
      mStrobe = 1'b0;
    end
    bPipe[1]  = bPipe[0];
    bPipe[0]  = btn;
    swPipe[1] = swPipe[0];
    swPipe[0] = switches;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    checkBit({tag, " flagIN"}, flagIN, mAck);
    checkBit({tag, " in_waiting"}, in_waiting, mWaiting);
    checkBit({tag, " out_strobe"}, out_strobe, mStrobe);
    checkOutput({tag, " in_data"}, in_data, mInData);
    checkOutput({tag, " out_display"}, out_display, mDisp);
  endtask

  // Drive inputs at the falling edge, advance one rising edge, return at the next falling edge
  task automatic applyStimulus(input logic ir, input logic orq, input logic b,
                               input logic [31:0] sw, input logic [31:0] od);
    in_req   = ir;
    out_req  = orq;
    btn      = b;
    switches = sw;
    out_data = od;
    @(posedge clock);
    modelStep();
    @(negedge clock);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkModel(tag);
    end
  endtask

  typedef struct {
    logic        inReq;
    logic        outReq;
    logic        btn;
    logic [31:0] outData;
    logic        expFlag;
    logic        expWaiting;
    logic        expStrobe;
    logic [31:0] expDisplay;
    logic [31:0] expInData;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic orq, input logic b, input logic [31:0] od,
                              input logic f, input logic w, input logic s,
                              input logic [31:0] d, input logic [31:0] idat);
    vec_t v;
    v.inReq = ir; v.outReq = orq; v.btn = b; v.outData = od;
    v.expFlag = f; v.expWaiting = w; v.expStrobe = s;
    v.expDisplay = d; v.expInData = idat;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    logic        seen;
    int          latency;
    int          flags;
    localparam logic [31:0] SW_A = 32'hA5A5_0003;

    tests    = 0;
    failures = 0;

    // Basic IN (btn first sampled at row 1 = E0, flagIN after E6 = row 7), then OUT 7, 9
    vecs[0]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) vecs[i] = mk(1, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(1, 0, 1, 0, 1, 0, 0, 0, SW_A);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, SW_A);
    vecs[9]  = mk(0, 1, 0, 7, 0, 0, 1, 7, SW_A);
    vecs[10] = mk(0, 1, 0, 9, 0, 0, 1, 9, SW_A);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 9, SW_A);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 9, SW_A);

    reset = 1'b1; in_req = 1'b0; out_req = 1'b0; btn = 1'b0;
    switches = '0; out_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    checkBit("reset flagIN", flagIN, 1'b0);
    checkBit("reset in_waiting", in_waiting, 1'b0);
    checkBit("reset out_strobe", out_strobe, 1'b0);
    checkOutput("reset in_data", in_data, 32'h0);
    checkOutput("reset out_display", out_display, 32'h0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].inReq, vecs[i].outReq, vecs[i].btn, SW_A, vecs[i].outData);
      checkBit($sformatf("vec%0d flagIN", i), flagIN, vecs[i].expFlag);
      checkBit($sformatf("vec%0d in_waiting", i), in_waiting, vecs[i].expWaiting);
      checkBit($sformatf("vec%0d out_strobe", i), out_strobe, vecs[i].expStrobe);
      checkOutput($sformatf("vec%0d out_display", i), out_display, vecs[i].expDisplay);
      checkOutput($sformatf("vec%0d in_data", i), in_data, vecs[i].expInData);
    end

    // Glitch rejection: 3-cycle pulse while waiting
    idle(8, "pre-glitch");
    applyStimulus(1, 0, 0, 32'h0000_00F0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 32'h0000_00F0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 32'h0000_00F0, 0);
      checkBit("glitch flagIN", flagIN, 1'b0);
      checkBit("glitch in_waiting", in_waiting, 1'b1);
      checkModel("glitch");
    end
    applyStimulus(0, 0, 0, 0, 0);

    // Held button across ACK with back-to-back IN
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1, 0, 1, 32'h1234_5678, 0);
      checkModel("held-first");
      if (flagIN) seen = 1'b1;
    end
    checkBit("held first flagIN seen", seen, 1'b1);
    flags = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 1, 32'h1234_5678, 0);
      checkModel("held");
      if (flagIN) flags++;
    end
    checkOutput("held no retrigger", 32'(flags), 32'd0);
    checkBit("held in_waiting", in_waiting, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 32'h1234_5678, 0);
      checkModel("release");
    end
    seen = 1'b0;
    latency = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      applyStimulus(1, 0, 1, 32'h1234_5678, 0);
      latency++;
      if (flagIN) seen = 1'b1;
    end
    checkBit("repress flagIN seen", seen, 1'b1);
    checkOutput("repress latency", 32'(latency), 32'd7);
    checkOutput("repress in_data", in_data, 32'h1234_5678);
    applyStimulus(1, 0, 1, 32'h1234_5678, 0);
    checkBit("repress single pulse", flagIN, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    idle(8, "post-held");

    // Abort in the same cycle the press fires
    applyStimulus(1, 0, 0, 32'hDEAD_BEEF, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 0);
      checkModel("abort-wait");
    end
    applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 0);
    checkBit("abort flagIN", flagIN, 1'b0);
    checkBit("abort in_waiting", in_waiting, 1'b0);
    checkOutput("abort in_data", in_data, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 0);
      checkBit("abort no late flagIN", flagIN, 1'b0);
      checkModel("abort-after");
    end
    idle(8, "post-abort");

    // Reset asserted mid-WAIT_PRESS
    applyStimulus(0, 1, 0, 0, 32'h55);
    applyStimulus(1, 0, 0, 32'h0BAD_F00D, 0);
    checkBit("pre-reset in_waiting", in_waiting, 1'b1);
    #1 reset = 1'b1;
    #1;
    checkBit("midreset flagIN", flagIN, 1'b0);
    checkBit("midreset in_waiting", in_waiting, 1'b0);
    checkBit("midreset out_strobe", out_strobe, 1'b0);
    checkOutput("midreset in_data", in_data, 32'h0);
    checkOutput("midreset out_display", out_display, 32'h0);
    @(posedge clock);
    @(negedge clock);
    in_req = 1'b0;
    reset  = 1'b0;
    modelReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, 32'h0BAD_F00D, 0);
      checkBit("postreset flagIN", flagIN, 1'b0);
      checkModel("postreset");
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 1, 32'h0BAD_F00D, 0);
      checkBit("postreset held flagIN", flagIN, 1'b0);
      checkModel("postreset-held");
    end
    idle(8, "post-reset");

    // Randomized traffic against the model
    begin
      logic ir;
      logic b;
      ir = 1'b0;
      b  = 1'b0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(15) == 0) ir = ~ir;
        if ($urandom_range(7) == 0) b = ~b;
        applyStimulus(ir, ($urandom_range(3) == 0), b, $urandom, $urandom);
        checkModel("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
